// File: rtl/fir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_pkg: shared constants and types for the 64-tap FIR MAC path  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fir_pkg;
  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 6;
  localparam int ACCW = DW + CW + AW;
  localparam int RND  = 2**14;

  localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_round_sat: round-half-up Q1.15 extraction with saturation    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fir_round_sat
  import fir_pkg::*;
(
  input  logic signed [ACCW-1:0] acc_i,
  output logic signed [DW-1:0]   data_o
);

  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shr;

  always_comb begin
    sum = acc_i + ACCW'(RND);
    shr = sum >>> (DW - 1);
    // In range only when every bit above the Q1.15 sign bit copies it
    if ((shr[ACCW-1:DW-1] == '0) || (shr[ACCW-1:DW-1] == '1)) begin
      data_o = shr[DW-1:0];
    end else if (shr[ACCW-1]) begin
      data_o = SAT_MIN;
    end else begin
      data_o = SAT_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_mac_seq: tap-walk sequencer and pipelined MAC, one output    |
// | sample per strobe. Rev 1.0                                       |
// +------------------------------------------------------------------+
module fir_mac_seq
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_strobe,
  output logic [AW-1:0]        read_addr,
  input  logic signed [DW-1:0] data_in,
  input  logic signed [CW-1:0] coef_in,
  output logic signed [DW-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int              PW       = DW + CW;
  localparam logic [AW-1:0]   LAST_TAP = AW'(TAPS - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic signed [PW-1:0]   data_ext, coef_ext, prod_d, prod_q;
  logic signed [ACCW-1:0] prod_ext, acc_q;
  logic                   p_vld_q, p_first_q, p_last_q, a_last_q;
  logic signed [DW-1:0]   round_val, data_out_q;
  logic                   data_valid_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Counter wraps to 0 on the last tap, so it is already 0 on return to IDLE
        if (cnt_q == LAST_TAP) begin
          cnt_d = '0;
          if (!sample_strobe) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
          if (sample_strobe) overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  assign data_ext = {{CW{data_in[DW-1]}}, data_in};
  assign coef_ext = {{DW{coef_in[CW-1]}}, coef_in};
  assign prod_d   = data_ext * coef_ext;
  assign prod_ext = {{(ACCW-PW){prod_q[PW-1]}}, prod_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      prod_q       <= '0;
      p_vld_q      <= 1'b0;
      p_first_q    <= 1'b0;
      p_last_q     <= 1'b0;
      acc_q        <= '0;
      a_last_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      prod_q       <= prod_d;
      p_vld_q      <= busy_q;
      p_first_q    <= busy_q && (cnt_q == '0);
      p_last_q     <= busy_q && (cnt_q == LAST_TAP);
      if (p_vld_q) acc_q <= p_first_q ? prod_ext : acc_q + prod_ext;
      a_last_q     <= p_vld_q & p_last_q;
      data_valid_q <= a_last_q;
      if (a_last_q) data_out_q <= round_val;
    end
  end

  fir_round_sat u_round_sat (
    .acc_i  (acc_q),
    .data_o (round_val)
  );

  assign read_addr  = cnt_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule
`default_nettype wire

// File: doc/fir_mac_seq.md
# fir_mac_seq

Read-side sequencer and multiply-accumulate engine for the 64-tap, 16-bit FIR. It is the reader of the FIR sample shift memory. On each sample strobe it walks `read_addr` 0..63 across the delay line and the coefficient ROM, accumulating signed products in a pipeline. It then emits one rounded, saturated Q1.15 output sample per input sample. It sits between the shift memory (and coefficient ROM) and the output register stage.

## Interface
- `TAPS`, 64, number of taps / addresses walked
- `DW`, 16, sample width, signed Q1.15
- `CW`, 16, coefficient width, signed Q1.15
- `AW`, 6, address width, clog2(TAPS)
- `ACCW`, 38, accumulator width, DW+CW+AW

- `clk`  in  1  sample-processing clock (640 kHz domain)
- `reset`  in  1  synchronous, active-low
- `sample_strobe`  in  1  one-cycle pulse; high in the cycle ending with the edge at which the shift memory shifts in a new sample
- `read_addr`  out  AW  tap address to shift memory and coefficient ROM
- `data_in`  in  DW  shift-memory word at `read_addr`, combinational, same cycle
- `coef_in`  in  CW  coefficient at `read_addr`, combinational, same cycle
- `data_out`  out  DW  filtered sample, signed Q1.15
- `data_valid`  out  1  one-cycle pulse, `data_out` new
- `busy`  out  1  state is RUN
- `overrun`  out  1  sticky: strobe arrived mid-run

## Operation
- FSM has 2 states:
  - IDLE: `read_addr` = 0. When `sample_strobe` = 1, go to RUN and clear the tap counter.
  - RUN: `read_addr` = tap counter, which increments every cycle.
    - At count 63 with no strobe, go to IDLE.
    - At count 63 with a strobe, stay in RUN and restart at 0. This is the back-to-back case.
- A strobe in RUN with count < 63 is ignored. It sets `overrun`, and the current run completes unchanged.
- Pipeline stage 1: `prod` <= `data_in` * `coef_in`, 32-bit signed. Tags `p_vld`, `p_first` (addr 0) and `p_last` (addr 63) are carried with it.
- Pipeline stage 2: `acc` <= `p_first` ? sext(`prod`) : `acc` + sext(`prod`). Tag `a_last` <= `p_vld` & `p_last`.
- Output stage, when `a_last`:
  - `data_out` <= sat16((`acc` + 2^14) >>> 15), which rounds half up with an arithmetic shift.
  - Saturation limits are 32767 and -32768.
  - `data_valid` <= 1 for that cycle, and 0 otherwise.
- No overflow within ACCW: |acc| ≤ 2^36.
- Reset (sync, low) clears everything: state IDLE; `read_addr`, `data_out`, `acc`, `prod` = 0; all tags, `data_valid`, `busy`, `overrun` = 0. In-flight results are discarded and no `data_valid` follows.

## Timing
- Edge E0 samples the strobe. `read_addr` = k during the cycle after E(k), for k = 0..63.
- `prod` of tap k is captured at E(k+1), so the tap-63 read at E64 precedes the shift memory update at the same edge.
- `acc` is final at E65. `data_out` and `data_valid` update at E66, giving a latency of 66 cycles from strobe sampling.
- A strobe at E64 is accepted and `read_addr` returns to 0 after E64.
  - The new run's first `acc` load (E66) coincides with the old output capture. Both are nonblocking and correct.
  - The sustained rate is 1 output per 64 cycles.
- `busy` is registered and high during the cycles with a valid `read_addr`.

## Structure
- Package `fir_pkg`:
  - Constants: `TAPS`, `DW`, `CW`, `AW`, `ACCW`.
  - Rounding constant `RND = 2**14`.
  - Limits `SAT_MAX = 16'sh7FFF`, `SAT_MIN = 16'sh8000`.
  - State enum {IDLE, RUN}.
- Sub-module `fir_round_sat`: combinational, ACCW in, DW out. It is reused by any later decimator/output stage.
- The coefficient ROM stays external and is addressed by `read_addr`.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with strobes applied -> `read_addr` = 0, `data_out` = 0, `data_valid` = 0, `busy` = 0, `overrun` = 0.
- Impulse: tap0 = 0x4000, other taps 0, coef[0] = 0x2000, strobe at E0 -> `data_valid` at E66 only, with `data_out` = 0x1000.
- Saturation, positive: all taps 0x7FFF, all coefs 0x7FFF -> `data_out` = 0x7FFF.
- Saturation, negative: all taps 0x8000, all coefs 0x7FFF -> `data_out` = 0x8000.
- Rounding: tap0 = 0x0001 with coef[0] = 0x4000 gives acc = 0x4000 -> 0x0001. Tap0 = 0xFFFF with coef[0] = 0x4000 gives acc = -0x4000 -> 0x0000.
- Back-to-back: 4 strobes spaced 64 cycles with a shift-memory model -> 4 `data_valid` pulses spaced 64 cycles, each matching the golden dot product, and `overrun` = 0.
- Overrun and reset mid-run:
  - A strobe when `read_addr` = 10 -> `overrun` = 1 and the result equals the unperturbed run.
  - `reset` low when `read_addr` = 30 -> next cycle IDLE, and no `data_valid` afterwards.
